id_issue_queue: RTL and testbench

//  Parametrised multi-lane decode-to-issue buffer that replaces the single ID/issue pipeline register.

---
 rtl/id_issue_queue_pkg.sv | 34 +++
 rtl/id_issue_queue.sv | 126 ++++++++++++
 tb/tb_id_issue_queue.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/id_issue_queue_pkg.sv
// Shared types for the decode-to-issue queue: the decoded scoreboard entry and
// the queue slot that wraps it with its control-flow flag.
package id_issue_queue_pkg;

  typedef enum logic [2:0] {
    FU_NONE,
    FU_ALU,
    FU_BRANCH,
    FU_LOAD,
    FU_STORE,
    FU_MULT,
    FU_CSR
  } fu_t;

  typedef struct packed {
    logic [31:0] pc;
    fu_t         fu;
    logic [7:0]  op;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
  } scoreboard_entry_t;

  typedef struct packed {
    scoreboard_entry_t sbe;
    logic              is_ctrl_flow;
  } id_queue_entry_t;

  // A single-entry queue still needs a one-bit pointer to stay legal SV.
  function automatic int unsigned ptr_width(int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/id_issue_queue.sv
// Multi-lane in-order decode-to-issue queue. Accepts a valid prefix of decoded
// lanes per cycle and presents the oldest entries to issue from flopped storage.
module id_issue_queue
  import id_issue_queue_pkg::*;
#(
  parameter int unsigned NrFetchPorts = 2,
  parameter int unsigned NrIssuePorts = 2,
  parameter int unsigned Depth        = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         flush_i,
  input  scoreboard_entry_t            dec_entry_i [NrFetchPorts],
  input  logic [NrFetchPorts-1:0]      dec_ctrl_flow_i,
  input  logic [NrFetchPorts-1:0]      dec_valid_i,
  output logic [NrFetchPorts-1:0]      dec_ready_o,
  output scoreboard_entry_t            issue_entry_o [NrIssuePorts],
  output logic [NrIssuePorts-1:0]      issue_ctrl_o,
  output logic [NrIssuePorts-1:0]      issue_valid_o,
  input  logic [NrIssuePorts-1:0]      issue_ack_i,
  output logic [$clog2(Depth+1)-1:0]   count_o
);

  localparam int unsigned PtrW = ptr_width(Depth);
  localparam int unsigned CntW = $clog2(Depth + 1);
  localparam int unsigned MaxW = (NrFetchPorts > NrIssuePorts) ? NrFetchPorts : NrIssuePorts;

  id_queue_entry_t mem_reg [Depth];
  logic [PtrW-1:0] head_reg, head_next;
  logic [PtrW-1:0] tail_reg, tail_next;
  logic [CntW-1:0] count_reg, count_next;

  int unsigned              pops;
  int unsigned              pushes;
  int unsigned              free_slots;
  logic [NrFetchPorts-1:0]  push_mask;
  id_queue_entry_t          wr_entry [NrFetchPorts];
  logic [PtrW-1:0]          wr_idx   [NrFetchPorts];

  function automatic logic [PtrW-1:0] wrap_idx(logic [PtrW-1:0] base, int unsigned off);
    int unsigned sum;
    sum = 32'(base) + off;
    return PtrW'(sum % Depth);
  endfunction

  function automatic int unsigned count_ones(logic [MaxW-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < MaxW; i++) begin
      n = n + 32'(v[i]);
    end
    return n;
  endfunction

  // Acks are a prefix, so their popcount is the number of retiring head entries;
  // space they free is reusable in the same cycle.
  always_comb begin
    pops       = count_ones(MaxW'(issue_ack_i));
    free_slots = Depth - 32'(count_reg) + pops;
  end

  for (genvar gi = 0; gi < NrFetchPorts; gi++) begin : g_fetch
    assign dec_ready_o[gi] = (gi < free_slots);
    assign push_mask[gi]   = dec_valid_i[gi] & dec_ready_o[gi];
    assign wr_entry[gi]    = '{sbe: dec_entry_i[gi], is_ctrl_flow: dec_ctrl_flow_i[gi]};
    assign wr_idx[gi]      = wrap_idx(tail_reg, gi);
  end

  always_comb begin
    pushes     = count_ones(MaxW'(push_mask));
    head_next  = wrap_idx(head_reg, pops);
    tail_next  = wrap_idx(tail_reg, pushes);
    count_next = CntW'(32'(count_reg) + pushes - pops);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
      mem_reg   <= '{default: '0};
    end else begin
      // Lanes accepted during a flush are consumed but never stored.
      if (flush_i) begin
        head_reg  <= '0;
        tail_reg  <= '0;
        count_reg <= '0;
      end else begin
        head_reg  <= head_next;
        tail_reg  <= tail_next;
        count_reg <= count_next;
        for (int k = 0; k < NrFetchPorts; k++) begin
          if (push_mask[k]) begin
            mem_reg[wr_idx[k]] <= wr_entry[k];
          end
        end
      end
    end
  end

  for (genvar gi = 0; gi < NrIssuePorts; gi++) begin : g_issue
    id_queue_entry_t rd_entry;
    assign rd_entry           = mem_reg[wrap_idx(head_reg, gi)];
    assign issue_valid_o[gi]  = (32'(count_reg) > gi);
    assign issue_entry_o[gi]  = rd_entry.sbe;
    assign issue_ctrl_o[gi]   = rd_entry.is_ctrl_flow;
  end

  assign count_o = count_reg;

  logic [NrFetchPorts-1:0] dec_valid_inc;
  logic [NrIssuePorts-1:0] issue_ack_inc;
  assign dec_valid_inc = dec_valid_i + NrFetchPorts'(1);
  assign issue_ack_inc = issue_ack_i + NrIssuePorts'(1);

  // A vector is a prefix exactly when adding one clears every set bit.
  a_valid_prefix: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (dec_valid_i & dec_valid_inc) == '0);
  a_ack_prefix: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (issue_ack_i & issue_ack_inc) == '0);
  a_ack_valid: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (issue_ack_i & ~issue_valid_o) == '0);
  a_count_range: assert property (@(posedge clk_i) disable iff (!rst_ni)
    32'(count_reg) <= Depth);

endmodule

// File: tb/tb_id_issue_queue.sv
// Bench for id_issue_queue: a directed table, reset and random traffic on a
// 2/2/4 queue against a FIFO model, plus a 1/1/1 legacy-mode instance.
module tb_id_issue_queue;
  import id_issue_queue_pkg::*;

  logic clk;
  logic rst_n;

  logic              flush;
  scoreboard_entry_t dec_entry [2];
  logic [1:0]        dec_ctrl, dec_valid, dec_ready;
  scoreboard_entry_t issue_entry [2];
  logic [1:0]        issue_ctrl, issue_valid, issue_ack;
  logic [2:0]        count;

  logic              l_flush;
  scoreboard_entry_t l_dec_entry [1];
  logic [0:0]        l_dec_ctrl, l_dec_valid, l_dec_ready;
  scoreboard_entry_t l_issue_entry [1];
  logic [0:0]        l_issue_ctrl, l_issue_valid, l_issue_ack;
  logic [0:0]        l_count;

  int checks = 0;
  int errors = 0;

  id_queue_entry_t mq[$];
  id_queue_entry_t lq[$];

  id_issue_queue #(.NrFetchPorts(2), .NrIssuePorts(2), .Depth(4)) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .dec_entry_i(dec_entry), .dec_ctrl_flow_i(dec_ctrl), .dec_valid_i(dec_valid),
    .dec_ready_o(dec_ready), .issue_entry_o(issue_entry), .issue_ctrl_o(issue_ctrl),
    .issue_valid_o(issue_valid), .issue_ack_i(issue_ack), .count_o(count)
  );

  id_issue_queue #(.NrFetchPorts(1), .NrIssuePorts(1), .Depth(1)) dut_legacy (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(l_flush),
    .dec_entry_i(l_dec_entry), .dec_ctrl_flow_i(l_dec_ctrl), .dec_valid_i(l_dec_valid),
    .dec_ready_o(l_dec_ready), .issue_entry_o(l_issue_entry), .issue_ctrl_o(l_issue_ctrl),
    .issue_valid_o(l_issue_valid), .issue_ack_i(l_issue_ack), .count_o(l_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, errors=%0d", errors);
    $fatal(1);
  end

  function automatic void chk(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic scoreboard_entry_t rand_sbe();
    scoreboard_entry_t s;
    s.pc  = $urandom;
    s.fu  = fu_t'(3'($urandom_range(0, 6)));
    s.op  = 8'($urandom);
    s.rs1 = 5'($urandom);
    s.rs2 = 5'($urandom);
    s.rd  = 5'($urandom);
    return s;
  endfunction

  // One clock of the 4-deep queue; called just after a falling edge.
  task automatic main_cycle(input logic [1:0] dv, input logic [1:0] ack, input logic fl,
                            input logic use_tab, input logic [1:0] t_ready,
                            input int t_cnt, input logic [1:0] t_iv);
    int sz, pops, free;
    logic [1:0] m_ready, m_iv;
    dec_valid = dv;
    issue_ack = ack;
    flush     = fl;
    for (int k = 0; k < 2; k++) begin
      dec_entry[k] = rand_sbe();
      dec_ctrl[k]  = 1'($urandom_range(0, 1));
    end
    #1;
    sz      = mq.size();
    pops    = int'(ack[0]) + int'(ack[1]);
    free    = 4 - sz + pops;
    m_ready = {free > 1, free > 0};
    m_iv    = {sz > 1, sz > 0};
    $display("cycle dv=%b ack=%b flush=%b ready=%b valid=%b count=%0d", dv, ack, fl,
             dec_ready, issue_valid, count);
    if (use_tab) begin
      chk("tab_ready", dec_ready, t_ready);
      chk("tab_count", count, t_cnt);
      chk("tab_valid", issue_valid, t_iv);
    end else begin
      chk("ready", dec_ready, m_ready);
      chk("count", count, sz);
      chk("valid", issue_valid, m_iv);
    end
    for (int j = 0; j < 2 && j < sz; j++) begin
      chk("entry", {issue_entry[j], issue_ctrl[j]}, mq[j]);
    end
    if (fl) begin
      mq.delete();
    end else begin
      for (int p = 0; p < pops; p++) void'(mq.pop_front());
      for (int k = 0; k < 2; k++) begin
        if (dv[k] && k < free) mq.push_back('{sbe: dec_entry[k], is_ctrl_flow: dec_ctrl[k]});
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // One clock of the legacy single-register stage: ready = !valid || ack.
  task automatic legacy_cycle(input logic dv, input logic ack);
    int sz;
    logic exp_ready;
    l_dec_valid    = dv;
    l_issue_ack    = ack;
    l_dec_entry[0] = rand_sbe();
    l_dec_ctrl     = 1'($urandom_range(0, 1));
    #1;
    sz        = lq.size();
    exp_ready = (sz == 0) || ack;
    $display("legacy dv=%b ack=%b ready=%b valid=%b", dv, ack, l_dec_ready, l_issue_valid);
    chk("legacy_ready", l_dec_ready, exp_ready);
    chk("legacy_count", l_count, sz);
    chk("legacy_valid", l_issue_valid, sz > 0);
    if (sz > 0) chk("legacy_entry", {l_issue_entry[0], l_issue_ctrl[0]}, lq[0]);
    if (ack) void'(lq.pop_front());
    if (dv && exp_ready) lq.push_back('{sbe: l_dec_entry[0], is_ctrl_flow: l_dec_ctrl[0]});
    @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    logic [1:0] dv;
    logic [1:0] ack;
    logic       fl;
    logic [1:0] ready;
    int         cnt;
    logic [1:0] iv;
  } vec_t;

  vec_t tab [16];

  initial begin
    // Fill, full, full+ack, drain, flush at count 3, then wrap-around.
    tab[0]  = '{2'b11, 2'b00, 1'b0, 2'b11, 0, 2'b00};
    tab[1]  = '{2'b11, 2'b00, 1'b0, 2'b11, 2, 2'b11};
    tab[2]  = '{2'b11, 2'b00, 1'b0, 2'b00, 4, 2'b11};
    tab[3]  = '{2'b11, 2'b01, 1'b0, 2'b01, 4, 2'b11};
    tab[4]  = '{2'b00, 2'b11, 1'b0, 2'b11, 4, 2'b11};
    tab[5]  = '{2'b00, 2'b11, 1'b0, 2'b11, 2, 2'b11};
    tab[6]  = '{2'b01, 2'b00, 1'b0, 2'b11, 0, 2'b00};
    tab[7]  = '{2'b11, 2'b00, 1'b0, 2'b11, 1, 2'b01};
    tab[8]  = '{2'b11, 2'b01, 1'b1, 2'b11, 3, 2'b11};
    tab[9]  = '{2'b00, 2'b00, 1'b0, 2'b11, 0, 2'b00};
    tab[10] = '{2'b11, 2'b00, 1'b0, 2'b11, 0, 2'b00};
    tab[11] = '{2'b01, 2'b00, 1'b0, 2'b11, 2, 2'b11};
    tab[12] = '{2'b00, 2'b11, 1'b0, 2'b11, 3, 2'b11};
    tab[13] = '{2'b00, 2'b01, 1'b0, 2'b11, 1, 2'b01};
    tab[14] = '{2'b11, 2'b00, 1'b0, 2'b11, 0, 2'b00};
    tab[15] = '{2'b00, 2'b00, 1'b0, 2'b11, 2, 2'b11};

    rst_n          = 1'b0;
    flush          = 1'b0;
    dec_valid      = '0;
    dec_ctrl       = '0;
    issue_ack      = '0;
    dec_entry[0]   = '0;
    dec_entry[1]   = '0;
    l_flush        = 1'b0;
    l_dec_valid    = '0;
    l_dec_ctrl     = '0;
    l_issue_ack    = '0;
    l_dec_entry[0] = '0;

    @(negedge clk);
    @(negedge clk);
    chk("reset_count", count, 0);
    chk("reset_valid", issue_valid, 2'b00);
    chk("reset_ready", dec_ready, 2'b11);
    chk("reset_entry0", {issue_entry[0], issue_ctrl[0]}, 0);
    chk("reset_entry1", {issue_entry[1], issue_ctrl[1]}, 0);
    chk("reset_legacy_ready", l_dec_ready, 1'b1);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 16; i++) begin
      main_cycle(tab[i].dv, tab[i].ack, tab[i].fl, 1'b1, tab[i].ready, tab[i].cnt, tab[i].iv);
    end

    // Asynchronous reset with two entries queued, away from any clock edge.
    rst_n = 1'b0;
    #1;
    chk("midreset_count", count, 0);
    chk("midreset_valid", issue_valid, 2'b00);
    chk("midreset_entry0", {issue_entry[0], issue_ctrl[0]}, 0);
    mq.delete();
    @(negedge clk);
    rst_n = 1'b1;
    main_cycle(2'b01, 2'b00, 1'b0, 1'b0, 2'b00, 0, 2'b00);
    main_cycle(2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 0, 2'b00);

    for (int i = 0; i < 300; i++) begin
      int n_v, n_a, lim;
      logic [1:0] dv, ack;
      n_v = $urandom_range(0, 2);
      lim = (mq.size() < 2) ? mq.size() : 2;
      n_a = $urandom_range(0, lim);
      dv  = 2'((1 << n_v) - 1);
      ack = 2'((1 << n_a) - 1);
      main_cycle(dv, ack, ($urandom_range(0, 19) == 0), 1'b0, 2'b00, 0, 2'b00);
    end
    dec_valid = '0;
    issue_ack = '0;
    flush     = 1'b0;

    // Legacy stage: back-to-back traffic first, then random valid/ack.
    for (int i = 0; i < 10; i++) legacy_cycle(1'b1, lq.size() > 0);
    for (int i = 0; i < 40; i++) begin
      logic ack;
      ack = (lq.size() > 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      legacy_cycle(1'($urandom_range(0, 1)), ack);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
